// File: rtl/scan_step_counter.sv
// Windowed multi-channel pulse counter for the scan top level: counts synchronised rising
// edges over a programmable window opened by a DAC step pulse, then latches and handshakes.
module scan_step_counter #(
    parameter int         CHANNELS    = 4,
    parameter int         CNT_WIDTH   = 32,
    parameter logic [7:0] BASE_ADDR   = 8'h40,
    parameter int         SYNC_STAGES = 2
) (
    input  logic                 clock50Mhz,
    input  logic                 reset,
    input  logic [7:0]           addr,
    input  logic [7:0]           data,
    input  logic                 write,
    output logic [7:0]           data_out,
    input  logic [CHANNELS-1:0]  cnt_in,
    input  logic                 step_start,
    output logic                 step_done,
    input  logic                 host_read,
    output logic [31:0]          time_export,
    output logic [CNT_WIDTH-1:0] signals_export,
    output logic [2:0]           dbg_state_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARM   = 3'd1,
        S_COUNT = 3'd2,
        S_LATCH = 3'd3,
        S_HOLD  = 3'd4
    } state_t;

    state_t state_q, state_d;

    logic                 enable_q, auto_q, missed_q, ovf_q;
    logic [31:0]          win_q, wcnt_q, ts_q, time_q;
    logic [7:0]           chsel_q;
    logic [CNT_WIDTH-1:0] cnt_q [CHANNELS];
    logic [CNT_WIDTH-1:0] res_q [CHANNELS];
    logic [CHANNELS-1:0]  sync_q [SYNC_STAGES];
    logic [CHANNELS-1:0]  prev_q;
    logic [CHANNELS-1:0]  det;
    logic [CNT_WIDTH-1:0] sel_cnt;
    logic [31:0]          sel32;
    logic [8:0]           addr_diff;
    logic                 hit, clear_req, start_win;
    logic [3:0]           off;

    // Subtract in 9 bits so addresses below BASE_ADDR wrap out of the 0..15 range.
    assign addr_diff = {1'b0, addr} - {1'b0, BASE_ADDR};
    assign hit       = (addr_diff < 9'd16);
    assign off       = addr_diff[3:0];
    assign clear_req = write && hit && (off == 4'd0) && data[2];
    assign det       = sync_q[SYNC_STAGES-1] & ~prev_q;
    assign start_win = (state_q == S_ARM) && (state_d == S_COUNT);

    always_ff @(posedge clock50Mhz or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
            prev_q <= '0;
            ts_q   <= '0;
        end else begin
            sync_q[0] <= cnt_in;
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
            prev_q <= sync_q[SYNC_STAGES-1];
            ts_q   <= ts_q + 32'd1;
        end
    end

    always_ff @(posedge clock50Mhz or posedge reset) begin
        if (reset) begin
            enable_q <= 1'b0;
            auto_q   <= 1'b0;
            win_q    <= 32'd1;
            chsel_q  <= '0;
        end else if (write && hit) begin
            case (off)
                4'd0: begin
                    enable_q <= data[0];
                    auto_q   <= data[1];
                end
                4'd1: win_q[7:0]   <= data;
                4'd2: win_q[15:8]  <= data;
                4'd3: win_q[23:16] <= data;
                4'd4: win_q[31:24] <= data;
                4'd5: chsel_q      <= data;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock50Mhz or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (clear_req) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (enable_q) state_d = S_ARM;
                S_ARM: begin
                    if (!enable_q)       state_d = S_IDLE;
                    else if (step_start) state_d = S_COUNT;
                end
                S_COUNT: begin
                    if (!enable_q)               state_d = S_IDLE;
                    else if (wcnt_q == 32'd1)    state_d = S_LATCH;
                end
                S_LATCH: state_d = S_HOLD;
                S_HOLD:  if (host_read) state_d = (auto_q && enable_q) ? S_ARM : S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock50Mhz or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_q[i] <= '0;
                res_q[i] <= '0;
            end
            wcnt_q   <= '0;
            time_q   <= '0;
            ovf_q    <= 1'b0;
            missed_q <= 1'b0;
        end else if (clear_req) begin
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_q[i] <= '0;
                res_q[i] <= '0;
            end
            wcnt_q   <= '0;
            time_q   <= '0;
            ovf_q    <= 1'b0;
            missed_q <= 1'b0;
        end else begin
            if (start_win) begin
                for (int i = 0; i < CHANNELS; i++) cnt_q[i] <= '0;
                wcnt_q <= (win_q == 32'd0) ? 32'd1 : win_q;
            end else if (state_q == S_COUNT) begin
                wcnt_q <= wcnt_q - 32'd1;
                // Saturate rather than wrap; a dropped increment marks overflow.
                for (int i = 0; i < CHANNELS; i++) begin
                    if (det[i]) begin
                        if (&cnt_q[i]) ovf_q    <= 1'b1;
                        else           cnt_q[i] <= cnt_q[i] + 1'b1;
                    end
                end
            end
            if (state_q == S_LATCH) begin
                for (int i = 0; i < CHANNELS; i++) res_q[i] <= cnt_q[i];
                time_q <= ts_q;
            end
            if (step_start && (state_q == S_COUNT || state_q == S_LATCH || state_q == S_HOLD))
                missed_q <= 1'b1;
        end
    end

    always_comb begin
        sel_cnt = '0;
        for (int i = 0; i < CHANNELS; i++)
            if (chsel_q == 8'(i)) sel_cnt = res_q[i];
    end

    always_comb begin
        sel32    = 32'(sel_cnt);
        data_out = '0;
        if (hit) begin
            case (off)
                4'd0:  data_out = {6'd0, auto_q, enable_q};
                4'd1:  data_out = win_q[7:0];
                4'd2:  data_out = win_q[15:8];
                4'd3:  data_out = win_q[23:16];
                4'd4:  data_out = win_q[31:24];
                4'd5:  data_out = chsel_q;
                4'd6:  data_out = {4'd0, missed_q, ovf_q, (state_q == S_HOLD),
                                   (state_q == S_ARM || state_q == S_COUNT)};
                4'd8:  data_out = sel32[7:0];
                4'd9:  data_out = sel32[15:8];
                4'd10: data_out = sel32[23:16];
                4'd11: data_out = sel32[31:24];
                default: data_out = '0;
            endcase
        end
    end

    always_comb begin
        step_done      = (state_q == S_LATCH);
        time_export    = time_q;
        signals_export = sel_cnt;
        dbg_state_o    = state_q;
    end

endmodule
